// File: rtl/id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg
//
// ID/EX pipeline register of the 5-stage RV32 core. Captures the decode
// control bundle and operands on every rising clk edge and presents them
// to EX one cycle later. Also detects load-use hazards against the
// instruction currently in EX, and honours EX stall and branch flush.
//
// Slot semantics: ex_valid=1 means the ex_* slot holds a real instruction.
// A bubble is ex_valid=0 with every control bit 0. The EX slot advances
// on every edge unless ex_stall=1, which holds it. A pending flush always
// wins, even over ex_stall.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   id_*                decode-stage control bits, operands and indices
//   ex_stall            EX/MEM cannot accept; hold ex_* contents
//   flush               branch taken; kill the decode slot (load bubble)
//   ex_*                registered copies of the id_* inputs
//   hazard_stall        combinational load-use stall for PC and IF/ID
//   bubble_count        (only with ID_EX_PERF_CNT_EN) saturating count of
//                       bubbles loaded by hazard_stall or flush
//
// Configuration macro: ID_EX_PERF_CNT_EN enables bubble_count.
// ---------------------------------------------------------------------------
module id_ex_stage_reg #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        id_alu_op,
   input  logic              id_alu_src,
   input  logic              id_branch,
   input  logic              id_mem_read,
   input  logic              id_mem_write,
   input  logic              id_reg_write,
   input  logic              id_mem_to_reg,
   input  logic              id_valid,
   input  logic [XLEN-1:0]   id_pc,
   input  logic [XLEN-1:0]   id_rs1_data,
   input  logic [XLEN-1:0]   id_rs2_data,
   input  logic [XLEN-1:0]   id_imm,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [3:0]        id_funct,
   input  logic              ex_stall,
   input  logic              flush,
   output logic [1:0]        ex_alu_op,
   output logic              ex_alu_src,
   output logic              ex_branch,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic              ex_reg_write,
   output logic              ex_mem_to_reg,
   output logic              ex_valid,
   output logic [XLEN-1:0]   ex_pc,
   output logic [XLEN-1:0]   ex_rs1_data,
   output logic [XLEN-1:0]   ex_rs2_data,
   output logic [XLEN-1:0]   ex_imm,
   output logic [REG_AW-1:0] ex_rs1,
   output logic [REG_AW-1:0] ex_rs2,
   output logic [REG_AW-1:0] ex_rd,
   output logic [3:0]        ex_funct,
   output logic              hazard_stall
`ifdef ID_EX_PERF_CNT_EN
   ,
   output logic [31:0]       bubble_count
`endif
);

   logic rs2_used;
   logic rd_match;

   // rs2 is only read when the second ALU operand is a register or the
   // instruction is a store (store data comes from rs2).
   assign rs2_used = ~id_alu_src | id_mem_write;

   // x0 is hardwired zero, so a load targeting it can never create a hazard.
   assign rd_match = (ex_rd != '0) &&
                     ((ex_rd == id_rs1) || (rs2_used && (ex_rd == id_rs2)));

   assign hazard_stall = ex_valid & ex_mem_read & rd_match & id_valid & ~flush;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_alu_op     <= '0;
         ex_alu_src    <= 1'b0;
         ex_branch     <= 1'b0;
         ex_mem_read   <= 1'b0;
         ex_mem_write  <= 1'b0;
         ex_reg_write  <= 1'b0;
         ex_mem_to_reg <= 1'b0;
         ex_valid      <= 1'b0;
         ex_pc         <= '0;
         ex_rs1_data   <= '0;
         ex_rs2_data   <= '0;
         ex_imm        <= '0;
         ex_rs1        <= '0;
         ex_rs2        <= '0;
         ex_rd         <= '0;
         ex_funct      <= '0;
      end else if (flush || (!ex_stall && hazard_stall)) begin
         // Bubble: flush overrides a stall; a hazard only bubbles when
         // the slot is free to advance.
         ex_alu_op     <= '0;
         ex_alu_src    <= 1'b0;
         ex_branch     <= 1'b0;
         ex_mem_read   <= 1'b0;
         ex_mem_write  <= 1'b0;
         ex_reg_write  <= 1'b0;
         ex_mem_to_reg <= 1'b0;
         ex_valid      <= 1'b0;
         ex_pc         <= '0;
         ex_rs1_data   <= '0;
         ex_rs2_data   <= '0;
         ex_imm        <= '0;
         ex_rs1        <= '0;
         ex_rs2        <= '0;
         ex_rd         <= '0;
         ex_funct      <= '0;
      end else if (!ex_stall) begin
         // Controls are masked by id_valid so an empty decode slot can
         // never write memory or the register file. mem_to_reg is also
         // masked by reg_write because decode leaves it unspecified
         // when nothing is written back.
         ex_alu_op     <= id_valid ? id_alu_op : 2'b00;
         ex_alu_src    <= id_alu_src   & id_valid;
         ex_branch     <= id_branch    & id_valid;
         ex_mem_read   <= id_mem_read  & id_valid;
         ex_mem_write  <= id_mem_write & id_valid;
         ex_reg_write  <= id_reg_write & id_valid;
         ex_mem_to_reg <= id_mem_to_reg & id_reg_write & id_valid;
         ex_valid      <= id_valid;
         ex_pc         <= id_pc;
         ex_rs1_data   <= id_rs1_data;
         ex_rs2_data   <= id_rs2_data;
         ex_imm        <= id_imm;
         ex_rs1        <= id_rs1;
         ex_rs2        <= id_rs2;
         ex_rd         <= id_rd;
         ex_funct      <= id_funct;
      end
   end

`ifdef ID_EX_PERF_CNT_EN
   // Counts bubbles only; stall holds are not bubbles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bubble_count <= '0;
      end else if ((flush || (!ex_stall && hazard_stall)) &&
                   (bubble_count != 32'hFFFF_FFFF)) begin
         bubble_count <= bubble_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage_reg
//
// Directed-vector bench for id_ex_stage_reg. Each step drives one decode
// bundle on the falling edge, checks hazard_stall, and pushes the
// hand-written expected ex_* bundle; a monitor pops and compares one
// entry after every rising edge. Define ID_EX_PERF_CNT_EN to also check
// bubble_count.
// ---------------------------------------------------------------------------
module tb_id_ex_stage_reg;

   typedef struct packed {
      logic [1:0]  alu_op;
      logic        alu_src;
      logic        branch;
      logic        mem_read;
      logic        mem_write;
      logic        reg_write;
      logic        mem_to_reg;
      logic        valid;
      logic [31:0] pc;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [3:0]  funct;
   } bundle_t;

   localparam int BW = $bits(bundle_t);

   // clock / reset
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic [1:0]  id_alu_op = '0;
   logic        id_alu_src = 1'b0, id_branch = 1'b0, id_mem_read = 1'b0;
   logic        id_mem_write = 1'b0, id_reg_write = 1'b0, id_mem_to_reg = 1'b0;
   logic        id_valid = 1'b0;
   logic [31:0] id_pc = '0, id_rs1_data = '0, id_rs2_data = '0, id_imm = '0;
   logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
   logic [3:0]  id_funct = '0;
   logic        ex_stall = 1'b0, flush = 1'b0;

   logic [1:0]  ex_alu_op;
   logic        ex_alu_src, ex_branch, ex_mem_read, ex_mem_write;
   logic        ex_reg_write, ex_mem_to_reg, ex_valid;
   logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
   logic [3:0]  ex_funct;
   logic        hazard_stall;
`ifdef ID_EX_PERF_CNT_EN
   logic [31:0] bubble_count;
`endif

   id_ex_stage_reg #(.XLEN(32), .REG_AW(5)) dut (
      .clk(clk), .reset(reset),
      .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_branch(id_branch),
      .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
      .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
      .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1),
      .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct),
      .ex_stall(ex_stall), .flush(flush),
      .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_branch(ex_branch),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
      .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
      .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct(ex_funct),
      .hazard_stall(hazard_stall)
`ifdef ID_EX_PERF_CNT_EN
      , .bubble_count(bubble_count)
`endif
   );

   logic [BW-1:0] act;
   assign act = {ex_alu_op, ex_alu_src, ex_branch, ex_mem_read, ex_mem_write,
                 ex_reg_write, ex_mem_to_reg, ex_valid, ex_pc, ex_rs1_data,
                 ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct};

   // scoreboard
   logic [BW-1:0] exp_q[$];
   int n_checks = 0;
   int n_fail = 0;
   int step_no = 0;

   function automatic bundle_t mk(input logic v, input logic [1:0] op,
                                  input logic src, input logic br,
                                  input logic mr, input logic mw,
                                  input logic rw, input logic m2r,
                                  input logic [31:0] pc, input logic [31:0] r1d,
                                  input logic [31:0] r2d, input logic [31:0] imm,
                                  input logic [4:0] r1, input logic [4:0] r2,
                                  input logic [4:0] rd, input logic [3:0] fn);
      bundle_t b;
      b.valid = v; b.alu_op = op; b.alu_src = src; b.branch = br;
      b.mem_read = mr; b.mem_write = mw; b.reg_write = rw; b.mem_to_reg = m2r;
      b.pc = pc; b.rs1_data = r1d; b.rs2_data = r2d; b.imm = imm;
      b.rs1 = r1; b.rs2 = r2; b.rd = rd; b.funct = fn;
      return b;
   endfunction

   // driver: one decode slot per cycle
   task automatic step(input bundle_t id, input logic stall, input logic fl,
                       input logic exp_haz, input bundle_t exp_ex);
      @(negedge clk);
      step_no++;
      id_valid = id.valid; id_alu_op = id.alu_op; id_alu_src = id.alu_src;
      id_branch = id.branch; id_mem_read = id.mem_read;
      id_mem_write = id.mem_write; id_reg_write = id.reg_write;
      id_mem_to_reg = id.mem_to_reg; id_pc = id.pc;
      id_rs1_data = id.rs1_data; id_rs2_data = id.rs2_data; id_imm = id.imm;
      id_rs1 = id.rs1; id_rs2 = id.rs2; id_rd = id.rd; id_funct = id.funct;
      ex_stall = stall; flush = fl;
      #1;
      n_checks++;
      if (hazard_stall !== exp_haz) begin
         n_fail++;
         $display("FAIL hazard_stall step %0d: got %b want %b", step_no, hazard_stall, exp_haz);
      end
      exp_q.push_back(exp_ex);
   endtask

   task automatic check_count(input logic [31:0] want);
`ifdef ID_EX_PERF_CNT_EN
      n_checks++;
      if (bubble_count !== want) begin
         n_fail++;
         $display("FAIL bubble_count step %0d: got %0d want %0d", step_no, bubble_count, want);
      end
`else
      if (want == 32'hFFFF_FFFF) $display("unexpected count request");
`endif
   endtask

   // monitor: one expected bundle per rising edge while entries are queued
   initial begin
      logic [BW-1:0] exp_v;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            n_checks++;
            if (act !== exp_v) begin
               n_fail++;
               $display("FAIL ex_bundle step %0d: got %h want %h", step_no, act, exp_v);
            end
         end
      end
   end

   bundle_t add3, lw5, add6, lw5b, addi6, lw0, addr0, sw_id, sw_ex, inv_id, inv_ex, bub;

   initial begin
      bub    = '0;
      add3   = mk(1, 2'b10, 0, 0, 0, 0, 1, 0, 32'h10, 32'h11, 32'h22, 32'h0, 5'd1, 5'd2, 5'd3, 4'h0);
      lw5    = mk(1, 2'b00, 1, 0, 1, 0, 1, 1, 32'h14, 32'h100, 32'h0, 32'h8, 5'd2, 5'd0, 5'd5, 4'h2);
      add6   = mk(1, 2'b10, 0, 0, 0, 0, 1, 0, 32'h18, 32'h55, 32'h11, 32'h0, 5'd5, 5'd1, 5'd6, 4'h0);
      lw5b   = mk(1, 2'b00, 1, 0, 1, 0, 1, 1, 32'h1c, 32'h200, 32'h0, 32'h4, 5'd2, 5'd0, 5'd5, 4'h2);
      addi6  = mk(1, 2'b00, 1, 0, 0, 0, 1, 0, 32'h20, 32'h0, 32'h77, 32'h5, 5'd0, 5'd5, 5'd6, 4'h0);
      lw0    = mk(1, 2'b00, 1, 0, 1, 0, 1, 1, 32'h24, 32'h300, 32'h0, 32'h0, 5'd2, 5'd0, 5'd0, 4'h2);
      addr0  = mk(1, 2'b10, 0, 0, 0, 0, 1, 0, 32'h28, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd6, 4'h0);
      sw_id  = mk(1, 2'b00, 1, 0, 0, 1, 0, 1'bx, 32'h2c, 32'h400, 32'hBEEF, 32'hC, 5'd2, 5'd7, 5'd0, 4'h2);
      sw_ex  = mk(1, 2'b00, 1, 0, 0, 1, 0, 0, 32'h2c, 32'h400, 32'hBEEF, 32'hC, 5'd2, 5'd7, 5'd0, 4'h2);
      inv_id = mk(0, 2'b11, 1, 1, 1, 1, 1, 1, 32'h30, 32'h9, 32'hA, 32'hB, 5'd4, 5'd8, 5'd9, 4'h5);
      inv_ex = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 32'h30, 32'h9, 32'hA, 32'hB, 5'd4, 5'd8, 5'd9, 4'h5);

      // reset state
      #3;
      n_checks++;
      if (act !== '0 || hazard_stall !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: got %h want 0", act);
      end
      check_count(0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      step(add3,  0, 0, 0, add3);    // plain ALU op
      step(lw5,   0, 0, 0, lw5);     // load x5
      step(add6,  0, 0, 1, bub);     // ADD x6,x5,x1: load-use bubble
      step(add6,  0, 0, 0, add6);    // exactly one bubble
      check_count(1);
      step(lw5b,  0, 0, 0, lw5b);
      step(addi6, 0, 0, 0, addi6);   // rs2 matches but is not used
      step(lw0,   0, 0, 0, lw0);
      step(addr0, 0, 0, 0, addr0);   // rd=x0 never hazards
      step(sw_id, 0, 0, 0, sw_ex);   // mem_to_reg X sanitised
      step(inv_id,0, 0, 0, inv_ex);  // invalid slot clears controls
      step(add3,  0, 0, 0, add3);
      step(lw5,   1, 0, 0, add3);    // stall holds for 3 cycles
      step(add6,  1, 0, 0, add3);
      step(sw_id, 1, 0, 0, add3);
      step(add6,  1, 1, 0, bub);     // flush beats stall
      check_count(2);
      step(add6,  0, 0, 0, add6);
      step(lw5,   0, 0, 0, lw5);
      step(add6,  1, 0, 1, lw5);     // hazard seen from held contents
      check_count(2);
      step(add6,  0, 0, 1, bub);
      check_count(3);
      step(lw5,   0, 0, 0, lw5);
      step(add6,  0, 1, 0, bub);     // flush masks hazard_stall
      check_count(4);
      step(add3,  0, 0, 0, add3);

      // asynchronous reset while stalling on valid contents
      @(negedge clk);
      ex_stall = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      n_checks++;
      if (act !== '0 || hazard_stall !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: got %h want 0", act);
      end
      check_count(0);
      @(negedge clk);
      reset = 1'b0;
      ex_stall = 1'b0;
      step(lw5, 0, 0, 0, lw5);       // recovers after reset

      // drain the scoreboard with a bounded wait
      for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: got %0d entries left want 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register directly downstream of the decode control unit in the 5-stage RV32 core.
- Captures the decode-stage control bundle and operands each cycle and presents them to the EX stage one cycle later.
- Detects load-use hazards, inserts bubbles, and honours downstream stall and branch flush.

Parameters:
XLEN, 32, datapath width (PC, register data, immediate)
REG_AW, 5, register index width

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-high
id_alu_op  in  2  ALUop from control unit
id_alu_src  in  1  ALUsrc
id_branch  in  1  Branch
id_mem_read  in  1  MemRead
id_mem_write  in  1  MemWrite
id_reg_write  in  1  RegWrite
id_mem_to_reg  in  1  MemToReg (may be X when RegWrite=0)
id_valid  in  1  decode slot holds a real instruction
id_pc  in  XLEN  instruction PC
id_rs1_data, id_rs2_data  in  XLEN  register file read data
id_imm  in  XLEN  sign-extended immediate
id_rs1, id_rs2, id_rd  in  REG_AW  register indices
id_funct  in  4  {funct7[5], funct3}
ex_stall  in  1  EX/MEM cannot accept; hold contents
flush  in  1  branch taken; kill decode slot
ex_* outputs  out  same widths  registered copies of every id_* input above (ex_alu_op, ex_alu_src, …, ex_funct, ex_valid)
hazard_stall  out  1  combinational; freeze PC and IF/ID

Behaviour:
- Reset (async, any time): all ex_* outputs 0, including ex_valid=0. A reset mid-stall discards held contents.
- Latency: 1 clock from id_* to ex_*.
- hazard_stall = ex_valid & ex_mem_read & (ex_rd!=0) & ((ex_rd==id_rs1) | (rs2_used & ex_rd==id_rs2)) & id_valid & !flush.
- rs2_used = !id_alu_src | id_mem_write.
- Per-edge update priority:
  1. flush=1: load a bubble, even when ex_stall=1.
  2. ex_stall=1: hold all ex_* unchanged. hazard_stall is still computed from held contents.
  3. hazard_stall=1: load a bubble.
  4. Otherwise: load id_*.
- Bubble: ex_valid and all control bits (alu_op, alu_src, branch, mem_read, mem_write, reg_write, mem_to_reg) = 0. Data and index fields are don't-care; the implementation zeroes them.
- X-sanitising on load: ex_mem_to_reg = id_mem_to_reg & id_reg_write. Any control bit is forced to 0 when id_valid=0.
- A load-use hazard yields exactly one bubble: the next cycle ex_mem_read=0, so the hazard clears.
- rd=x0 never triggers a hazard.

Optional Feature:
- Macro ID_EX_PERF_CNT_EN.
- Defined: adds output bubble_count [31:0]. Increments on every edge that loads a bubble due to hazard_stall or flush; it does not increment on ex_stall holds. Saturates at 0xFFFFFFFF. Async reset to 0.
- Undefined: no port, no counter logic.

Test Plan:
- Reset asserted mid-cycle with ex_valid=1 -> all ex_* are 0 immediately, before the next clk edge.
- ADD x3 (valid, reg_write=1, alu_op=10, pc=0x10) loaded -> next cycle ex_rd=3, ex_alu_op=10, ex_pc=0x10, ex_valid=1, hazard_stall=0.
- LW x5 in EX, then ADD x6,x5,x1 in ID -> hazard_stall=1. Next edge ex_valid=0 and controls 0; following cycle the ADD loads. Exactly one bubble (bubble_count=1 if enabled).
- LW x5 in EX, then ADDI x6,x0,5 with id_rs2=5 (alu_src=1, mem_write=0) -> hazard_stall=0, no bubble. The same case with LW x0 -> no hazard.
- ex_stall=1 for 3 cycles while id_* changes -> ex_* frozen. flush=1 during the stall -> bubble loaded at that edge.
- STORE with id_mem_to_reg=X -> ex_mem_to_reg=0, ex_mem_write=1, no X on any ex_* output.
